gcd_dispatch: RTL and testbench
===============================

Name: gcd_dispatch

Overview:
Request/result buffering stage that sits directly upstream and downstream of the GCD black-box core. Operand pairs are queued from a valid/ready source and issued to the core one at a time. Zero-operand requests are resolved locally, because the core never terminates on a zero operand. Core results are collected into an output FIFO with full back-pressure, and results are always delivered in request order.

Parameters:
W, 16, operand/result width; matches core port width
DEPTH, 4, entries in each of request FIFO and result FIFO; power of 2, >=2

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset; same net drives the core's reset
i_s_valid  in  1  upstream request valid
o_s_ready  out  1  upstream request ready (request FIFO not full)
i_s_a  in  W  operand a
i_s_b  in  W  operand b
o_m_valid  out  1  result valid (result FIFO not empty)
i_m_ready  in  1  downstream result ready
o_m_c  out  W  result = gcd(a,b), head of result FIFO
o_core_a  out  W  operand a to core
o_core_b  out  W  operand b to core
o_core_in_valid  out  1  start request to core
i_core_in_ready  in  1  core idle
i_core_out_valid  in  1  core result strobe; single cycle, cannot be stalled
i_core_c  in  W  core result
o_busy  out  1  FSM not IDLE, or either FIFO non-empty

Behaviour:
- Reset: i_rst synchronous, active-high, clock i_clk. Both FIFOs are emptied and the FSM enters IDLE.
- Reset output values: o_s_ready=1, o_m_valid=0, o_core_in_valid=0, o_busy=0, o_m_c=0, o_core_a=0, o_core_b=0.
- Reset mid-operation discards everything: in-flight work, queued requests and undelivered results.
- Request FIFO:
  - Push on i_s_valid && o_s_ready.
  - o_s_ready = count<DEPTH (registered count; no combinational path from i_s_valid).
  - Simultaneous push and pop when full is not allowed (ready is low). When not full, push and pop in the same cycle keep the count unchanged.
- Result FIFO:
  - Pop on o_m_valid && i_m_ready.
  - o_m_c is the head entry and is stable while o_m_valid && !i_m_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full, provided a slot was reserved (see IDLE).
  - Pointers wrap modulo DEPTH; counts are log2(DEPTH)+1 bits wide.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: acts only when the request FIFO is non-empty AND the result FIFO has a free slot (count<DEPTH, or a pop happens this cycle). Head = (a,b).
  - If a==0 or b==0: push a|b into the result FIFO, pop the request, stay IDLE. One request per cycle; gcd(0,0)=0.
  - Otherwise: go to ISSUE. The result slot is effectively reserved, because no other push can occur until WAIT completes.
- ISSUE:
  - o_core_in_valid=1; o_core_a/o_core_b = head a/b, held stable.
  - On i_core_in_ready=1: pop the request, go to WAIT.
- WAIT:
  - o_core_in_valid=0.
  - On i_core_out_valid: push i_core_c into the result FIFO, go to IDLE.
  - i_core_out_valid outside WAIT is ignored.
- o_core_a/o_core_b are registered and hold their last issued value outside ISSUE.
- Only one core operation is outstanding at a time, which guarantees in-order results.
- Latency:
  - Zero-bypass: request accepted in cycle t gives o_m_valid in cycle t+2 (earliest, empty FIFOs).
  - Core path: issue to result visible = core compute time + 1 cycle (registered result FIFO).
- Results are never dropped: a core strobe is accepted unconditionally in WAIT because its slot was reserved at IDLE.
- o_busy = (state!=IDLE) | req_count!=0 | res_count!=0.

Test Plan:
- Single core op: push (48,18), i_m_ready=1 -> o_core_in_valid pulse with a=48, b=18; later o_m_c=6 with o_m_valid for exactly one cycle; o_busy returns to 0.
- Zero bypass: push (0,7), (9,0), (0,0) -> results 7, 9, 0 in order; o_core_in_valid never asserted.
- Ordering, mixed: push (12,8), (0,5), (21,14) back-to-back -> outputs 4, 5, 7 in that order.
- Back-pressure: i_m_ready=0, push 9 pairs of (35,14) -> o_s_ready drops after 4 queued; exactly 4 results of 7 are held. No issue while the result FIFO is full and the 5th request is queued. Releasing i_m_ready drains all 9 results of 7, none lost or duplicated.
- Simultaneous push/pop at full result FIFO with i_m_ready=1 during a core strobe -> count unchanged, values in order.
- Reset in WAIT: issue (1000,3), assert i_rst for 1 cycle mid-compute -> o_m_valid=0, o_s_ready=1, o_busy=0. A following push of (6,4) yields 2.

Source files
------------

// File: rtl/gcd_dispatch.sv
// gcd_dispatch
//   Request/result buffering wrapper around the GCD black-box core.
//   Operand pairs are queued from a valid/ready source and issued to the core
//   one at a time. Pairs with a zero operand are answered locally, because the
//   core never terminates on a zero operand. Results are collected into an
//   output FIFO with full back-pressure and always leave in request order.
//
// Parameters
//   W      operand/result width (matches the core ports)
//   DEPTH  entries in each of the request and result FIFOs (power of 2, >=2)
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset (shared with core)
//   i_s_valid/o_s_ready   upstream request handshake, operands i_s_a/i_s_b
//   o_m_valid/i_m_ready   downstream result handshake, result o_m_c
//   o_core_a/o_core_b     operands to the core (registered, held outside ISSUE)
//   o_core_in_valid       start request to the core
//   i_core_in_ready       core idle
//   i_core_out_valid      single-cycle, unstallable core result strobe
//   i_core_c              core result
//   o_busy                FSM not idle or either FIFO non-empty
module gcd_dispatch #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_s_valid,
    output logic         o_s_ready,
    input  logic [W-1:0] i_s_a,
    input  logic [W-1:0] i_s_b,
    output logic         o_m_valid,
    input  logic         i_m_ready,
    output logic [W-1:0] o_m_c,
    output logic [W-1:0] o_core_a,
    output logic [W-1:0] o_core_b,
    output logic         o_core_in_valid,
    input  logic         i_core_in_ready,
    input  logic         i_core_out_valid,
    input  logic [W-1:0] i_core_c,
    output logic         o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0] state;

    // Request FIFO storage and control
    logic [W-1:0]  req_a_mem [DEPTH];
    logic [W-1:0]  req_b_mem [DEPTH];
    logic [AW-1:0] req_wr_ptr;
    logic [AW-1:0] req_rd_ptr;
    logic [CW-1:0] req_count;

    // Result FIFO storage and control
    logic [W-1:0]  res_mem [DEPTH];
    logic [AW-1:0] res_wr_ptr;
    logic [AW-1:0] res_rd_ptr;
    logic [CW-1:0] res_count;

    logic [W-1:0] head_a;
    logic [W-1:0] head_b;
    logic         head_zero;
    logic         req_push;
    logic         req_pop;
    logic         res_push;
    logic         res_pop;
    logic         res_has_slot;
    logic         idle_go;
    logic         bypass;
    logic         issue_accept;
    logic         core_done;
    logic [W-1:0] res_din;

    // ------------------------------------------------------------------
    // Handshake and dispatch decisions
    // ------------------------------------------------------------------
    assign o_s_ready = (req_count < DEPTH_C);
    assign req_push  = i_s_valid && o_s_ready;

    assign head_a    = req_a_mem[req_rd_ptr];
    assign head_b    = req_b_mem[req_rd_ptr];
    assign head_zero = (head_a == '0) || (head_b == '0);

    assign o_m_valid = (res_count != '0);
    assign res_pop   = o_m_valid && i_m_ready;

    // A pop in the same cycle frees a slot, so a full result FIFO that is
    // being drained still lets IDLE make progress.
    assign res_has_slot = (res_count < DEPTH_C) || res_pop;

    // Once IDLE leaves for ISSUE no other result push can happen until the
    // core answers, so the slot checked here stays reserved for that answer.
    assign idle_go      = (state == ST_IDLE) && (req_count != '0) && res_has_slot;
    assign bypass       = idle_go && head_zero;
    assign issue_accept = (state == ST_ISSUE) && i_core_in_ready;
    assign core_done    = (state == ST_WAIT) && i_core_out_valid;

    assign req_pop  = bypass || issue_accept;
    assign res_push = bypass || core_done;

    // gcd(x,0) = x and gcd(0,0) = 0, so OR of the operands is the answer.
    assign res_din = bypass ? (head_a | head_b) : i_core_c;

    // Head of the result FIFO; forced to zero when empty so the output is
    // defined straight out of reset even though storage is not cleared.
    assign o_m_c = o_m_valid ? res_mem[res_rd_ptr] : '0;

    assign o_core_in_valid = (state == ST_ISSUE);
    assign o_busy = (state != ST_IDLE) || (req_count != '0) || (res_count != '0);

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (req_push) begin
            req_a_mem[req_wr_ptr] <= i_s_a;
            req_b_mem[req_wr_ptr] <= i_s_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
            req_count  <= '0;
        end else begin
            if (req_push) begin
                req_wr_ptr <= req_wr_ptr + AW'(1);
            end
            if (req_pop) begin
                req_rd_ptr <= req_rd_ptr + AW'(1);
            end
            req_count <= req_count + CW'(req_push) - CW'(req_pop);
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    // At full with a simultaneous pop, the write lands on the slot being
    // read this cycle; the reader has already consumed the old value.
    always_ff @(posedge i_clk) begin
        if (res_push) begin
            res_mem[res_wr_ptr] <= res_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_count  <= '0;
        end else begin
            if (res_push) begin
                res_wr_ptr <= res_wr_ptr + AW'(1);
            end
            if (res_pop) begin
                res_rd_ptr <= res_rd_ptr + AW'(1);
            end
            res_count <= res_count + CW'(res_push) - CW'(res_pop);
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: one core operation outstanding at a time keeps results
    // in request order.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            o_core_a <= '0;
            o_core_b <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_go && !head_zero) begin
                        state    <= ST_ISSUE;
                        o_core_a <= head_a;
                        o_core_b <= head_b;
                    end
                end
                ST_ISSUE: begin
                    if (i_core_in_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_core_out_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Testbench for gcd_dispatch: directed scenarios plus randomized traffic,
// with a behavioural core model and an in-order result scoreboard.
module tb_gcd_dispatch;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_s_valid;
    logic         o_s_ready;
    logic [W-1:0] i_s_a;
    logic [W-1:0] i_s_b;
    logic         o_m_valid;
    logic         i_m_ready;
    logic [W-1:0] o_m_c;
    logic [W-1:0] o_core_a;
    logic [W-1:0] o_core_b;
    logic         o_core_in_valid;
    logic         i_core_in_ready;
    logic         i_core_out_valid;
    logic [W-1:0] i_core_c;
    logic         o_busy;

    always #5 i_clk = ~i_clk;

    gcd_dispatch #(.W(W), .DEPTH(DEPTH)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_s_valid        (i_s_valid),
        .o_s_ready        (o_s_ready),
        .i_s_a            (i_s_a),
        .i_s_b            (i_s_b),
        .o_m_valid        (o_m_valid),
        .i_m_ready        (i_m_ready),
        .o_m_c            (o_m_c),
        .o_core_a         (o_core_a),
        .o_core_b         (o_core_b),
        .o_core_in_valid  (o_core_in_valid),
        .i_core_in_ready  (i_core_in_ready),
        .i_core_out_valid (i_core_out_valid),
        .i_core_c         (i_core_c),
        .o_busy           (o_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    pair_t        src_q[$];
    pair_t        iss_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    int acc_cnt = 0;
    int iss_cnt = 0;
    int mv_cnt  = 0;
    logic [W-1:0] last_iss_a = '0;
    logic [W-1:0] last_iss_b = '0;

    bit   mon_en    = 1'b0;
    bit   rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b0;
    bit   gap_en    = 1'b0;
    bit   core_rand = 1'b0;
    int   lat_min   = 1;
    int   lat_max   = 4;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        int x = int'(a);
        int y = int'(b);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return W'($urandom);
            default: return W'($urandom_range(1, 255));
        endcase
    endfunction

    task automatic push_req(input int a, input int b);
        pair_t p;
        p.a = W'(a);
        p.b = W'(b);
        src_q.push_back(p);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        @(negedge i_clk);
        while ((src_q.size() != 0 || exp_q.size() != 0 || o_busy !== 1'b0) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        chk({name, "_drain_in_time"}, (n < budget), 1);
    endtask

    // Upstream driver: presents src_q in order, holding a pair until accepted.
    initial begin
        bit hs;
        i_s_valid = 1'b0;
        i_s_a     = '0;
        i_s_b     = '0;
        forever begin
            @(negedge i_clk);
            hs = i_s_valid && o_s_ready && !i_rst;
            @(posedge i_clk);
            #1;
            if (hs && src_q.size() > 0) src_q.delete(0);
            if (i_s_valid && !hs && src_q.size() > 0) begin
                i_s_valid = 1'b1;
            end else if (src_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                i_s_valid = 1'b1;
                i_s_a     = src_q[0].a;
                i_s_b     = src_q[0].b;
            end else begin
                i_s_valid = 1'b0;
            end
        end
    end

    // Downstream ready driver.
    initial begin
        i_m_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            i_m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    // Behavioural core: accepts when idle, answers after a random latency
    // with one strobe; may stall acceptance and emit stray strobes while idle.
    initial begin
        bit           take;
        bit           rs;
        bit           cbusy;
        int           cnt;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        logic [W-1:0] cres;
        cbusy = 1'b0;
        cnt   = 0;
        cres  = '0;
        i_core_in_ready  = 1'b1;
        i_core_out_valid = 1'b0;
        i_core_c         = '0;
        forever begin
            @(negedge i_clk);
            take = o_core_in_valid && i_core_in_ready && !i_rst;
            rs   = i_rst;
            ca   = o_core_a;
            cb   = o_core_b;
            @(posedge i_clk);
            #1;
            i_core_out_valid = 1'b0;
            if (rs) begin
                cbusy = 1'b0;
                i_core_in_ready = 1'b1;
            end else if (take) begin
                cbusy = 1'b1;
                i_core_in_ready = 1'b0;
                cnt  = $urandom_range(lat_min, lat_max);
                cres = ref_gcd(ca, cb);
            end else if (cbusy) begin
                cnt--;
                if (cnt <= 0) begin
                    i_core_out_valid = 1'b1;
                    i_core_c = cres;
                    cbusy = 1'b0;
                    i_core_in_ready = 1'b1;
                end
            end else begin
                i_core_in_ready = core_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (core_rand && $urandom_range(0, 7) == 0) begin
                    i_core_out_valid = 1'b1;
                    i_core_c = 16'hDEAD;
                end
            end
        end
    end

    // Scoreboard: every accepted request owes gcd(a,b) in order; every
    // request with two nonzero operands owes one core issue, in order.
    initial begin
        bit           prev_hold;
        logic [W-1:0] prev_c;
        logic [W-1:0] e;
        pair_t        p;
        prev_hold = 1'b0;
        prev_c    = '0;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                chk("busy_vs_pending", o_busy, (exp_q.size() != 0));
                chk("m_valid_without_pending", (o_m_valid && exp_q.size() == 0), 0);
                if (prev_hold) begin
                    chk("m_valid_held", o_m_valid, 1);
                    chk("m_c_held", o_m_c, prev_c);
                end
                if (o_core_in_valid) begin
                    if (iss_q.size() == 0) begin
                        chk("issue_unexpected", 1, 0);
                    end else begin
                        chk("issue_a", o_core_a, iss_q[0].a);
                        chk("issue_b", o_core_b, iss_q[0].b);
                    end
                end
                if (i_rst) begin
                    exp_q.delete();
                    iss_q.delete();
                    prev_hold = 1'b0;
                end else begin
                    if (o_core_in_valid && i_core_in_ready) begin
                        iss_cnt++;
                        last_iss_a = o_core_a;
                        last_iss_b = o_core_b;
                        if (iss_q.size() > 0) iss_q.delete(0);
                    end
                    if (o_m_valid && i_m_ready && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("m_c_in_order", o_m_c, e);
                        got_q.push_back(o_m_c);
                    end
                    if (i_s_valid && o_s_ready) begin
                        acc_cnt++;
                        exp_q.push_back(ref_gcd(i_s_a, i_s_b));
                        if (i_s_a != '0 && i_s_b != '0) begin
                            p.a = i_s_a;
                            p.b = i_s_b;
                            iss_q.push_back(p);
                        end
                    end
                    if (o_m_valid) mv_cnt++;
                    prev_hold = o_m_valid && !i_m_ready;
                    prev_c    = o_m_c;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int iss0;
        int acc0;
        int n7;
        int n;
        logic [W-1:0] exp5 [6];
        exp5 = '{16'd7, 16'd7, 16'd7, 16'd7, 16'd3, 16'd2};

        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_s_ready", o_s_ready, 1);
        chk("rst_m_valid", o_m_valid, 0);
        chk("rst_core_in_valid", o_core_in_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_m_c", o_m_c, 0);
        chk("rst_core_a", o_core_a, 0);
        chk("rst_core_b", o_core_b, 0);
        mon_en = 1'b1;

        // Single core operation
        rdy_fixed = 1'b1;
        repeat (2) @(negedge i_clk);
        got_q.delete();
        mv_cnt = 0;
        iss0 = iss_cnt;
        push_req(48, 18);
        wait_idle(200, "single");
        chk("single_issue_count", iss_cnt - iss0, 1);
        chk("single_issue_a", last_iss_a, 48);
        chk("single_issue_b", last_iss_b, 18);
        chk("single_result_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("single_result", got_q[0], 6);
        chk("single_valid_cycles", mv_cnt, 1);
        chk("single_busy_after", o_busy, 0);

        // Zero bypass
        got_q.delete();
        iss0 = iss_cnt;
        push_req(0, 7);
        push_req(9, 0);
        push_req(0, 0);
        wait_idle(200, "bypass");
        chk("bypass_no_issue", iss_cnt - iss0, 0);
        chk("bypass_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("bypass_r0", got_q[0], 7);
            chk("bypass_r1", got_q[1], 9);
            chk("bypass_r2", got_q[2], 0);
        end

        // Mixed ordering
        got_q.delete();
        push_req(12, 8);
        push_req(0, 5);
        push_req(21, 14);
        wait_idle(300, "mixed");
        chk("mixed_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("mixed_r0", got_q[0], 4);
            chk("mixed_r1", got_q[1], 5);
            chk("mixed_r2", got_q[2], 7);
        end

        // Back-pressure with a blocked sink
        rdy_fixed = 1'b0;
        repeat (2) @(negedge i_clk);
        got_q.delete();
        acc0 = acc_cnt;
        iss0 = iss_cnt;
        for (int i = 0; i < 9; i++) push_req(35, 14);
        repeat (80) @(negedge i_clk);
        chk("bp_accepted", acc_cnt - acc0, 2 * DEPTH);
        chk("bp_issued", iss_cnt - iss0, DEPTH);
        chk("bp_s_ready_low", o_s_ready, 0);
        chk("bp_m_valid", o_m_valid, 1);
        chk("bp_no_issue_when_full", o_core_in_valid, 0);
        chk("bp_head", o_m_c, 7);
        rdy_fixed = 1'b1;
        wait_idle(500, "bp");
        n7 = 0;
        foreach (got_q[i]) if (got_q[i] == 16'd7) n7++;
        chk("bp_result_count", got_q.size(), 9);
        chk("bp_all_seven", n7, 9);

        // Full result FIFO draining while a bypass pushes and a core op follows
        rdy_fixed = 1'b0;
        repeat (2) @(negedge i_clk);
        got_q.delete();
        for (int i = 0; i < 4; i++) push_req(35, 14);
        push_req(0, 3);
        push_req(10, 4);
        repeat (60) @(negedge i_clk);
        chk("full_m_valid", o_m_valid, 1);
        rdy_fixed = 1'b1;
        wait_idle(300, "full");
        chk("full_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) chk("full_order", got_q[i], exp5[i]);
        end

        // Reset while the core is computing
        lat_min = 12;
        lat_max = 12;
        iss0 = iss_cnt;
        push_req(1000, 3);
        n = 0;
        while (iss_cnt == iss0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk("rstwait_issued", (n < 100), 1);
        repeat (3) @(negedge i_clk);
        chk("rstwait_busy_before", o_busy, 1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rstwait_m_valid", o_m_valid, 0);
        chk("rstwait_s_ready", o_s_ready, 1);
        chk("rstwait_busy", o_busy, 0);
        lat_min = 1;
        lat_max = 4;
        repeat (20) @(negedge i_clk);
        chk("rstwait_no_late_result", o_m_valid, 0);
        got_q.delete();
        push_req(6, 4);
        wait_idle(200, "after_rst");
        chk("after_rst_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("after_rst_result", got_q[0], 2);

        // Randomized traffic
        rdy_rand  = 1'b1;
        gap_en    = 1'b1;
        core_rand = 1'b1;
        got_q.delete();
        acc0 = acc_cnt;
        for (int i = 0; i < 80; i++) begin
            pair_t p;
            p.a = pick_operand();
            p.b = pick_operand();
            src_q.push_back(p);
        end
        wait_idle(6000, "random");
        chk("random_accepted", acc_cnt - acc0, 80);
        chk("random_delivered", got_q.size(), 80);

        rdy_rand  = 1'b0;
        gap_en    = 1'b0;
        core_rand = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("final_busy", o_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
